mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Two-port round-robin front end for the `mem_ctrl` memory controller. It accepts single read or write requests from two independent requesters, serialises them onto the controller's command interface and holds each transaction until the controller signals completion. It then returns a one-cycle response to the originating port. It sits between the system-side masters and `mem_ctrl`, and is the only block that drives the controller's `cmd_n`, `RDnWR`, `Addr_in`, `Data_in` and `Data_in_vld` inputs.

## Interface
- `TIMEOUT_CYC`, default 64: maximum cycles in WAIT before the transaction is abandoned; legal range 2 to 255.
- `GAP_CYC`, default 2: cycles `mc_cmd_n` is held high between transactions; legal range 1 to 15.
- `clk`, in, 1: single clock; everything is rising-edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_vld`, in, 2: per-port request valid.
- `req_ready`, out, 2: per-port accept; combinational; at most one bit set.
- `req_rdnwr`, in, 2: per port, 1 = read, 0 = write.
- `req_addr`, in, 2x16: per-port address, packed `[1:0][15:0]`.
- `req_wdata`, in, 2x32: per-port write data.
- `rsp_vld`, out, 2: per-port one-cycle response pulse.
- `rsp_rdata`, out, 32: read data, shared by both ports; qualified by `rsp_vld`.
- `rsp_err`, out, 1: timeout flag; qualified by `rsp_vld`.
- `busy`, out, 1: high in every state except IDLE.
- `mc_cmd_n`, out, 1: goes to the controller's `cmd_n`; active low.
- `mc_rdnwr`, out, 1: goes to `RDnWR`.
- `mc_addr`, out, 16: goes to `Addr_in`.
- `mc_wdata`, out, 32: goes to `Data_in`.
- `mc_wdata_vld`, out, 1: goes to `Data_in_vld`.
- `mc_command`, in, 3: the controller's `command` output.
- `mc_rdata`, in, 32: the controller's `Data_out`.

## Operation
- States: IDLE, WAIT, CAPT, RESP, GAP.
- **IDLE, arbitration.** `req_ready[g]` is 1 only for the granted port `g`.
  - If only one port is valid, that port is granted.
  - If both are valid, the port other than `last_grant` is granted.
  - `last_grant` resets to 1, so port 0 wins the first conflict.
- **Accept.** A request is accepted on `req_vld[g] & req_ready[g]`. On the accept edge:
  - `mc_addr`, `mc_rdnwr` and `mc_wdata` are loaded from port `g`.
  - `mc_wdata_vld` takes the value of `~rdnwr`.
  - `mc_cmd_n` goes to 0.
  - `last_grant` is set to `g` and the timeout counter is cleared.
  - The state moves to WAIT.
- **WAIT.** All `mc_*` outputs are held stable, because the controller resamples `Addr_in` in several of its states.
  - Write: `mc_command == 3'b011` (CMD_WRITE) moves to RESP.
  - Read: `mc_command == 3'b010` (CMD_READ) moves to CAPT.
  - A command that does not match the request direction is ignored.
  - On either exit, `mc_cmd_n` goes to 1 and `mc_wdata_vld` to 0.
- **CAPT.** One cycle. `mc_rdata` is latched into `rsp_rdata`, then the state moves to RESP.
- **Timeout.** If the counter reaches `TIMEOUT_CYC-1` in WAIT with no completion:
  - Move to RESP with `rsp_err` = 1 and `rsp_rdata` = 0.
  - Release `mc_cmd_n`.
  - If completion and timeout happen in the same cycle, completion wins.
- **RESP.** `rsp_vld[g]` = 1 for exactly one cycle, `rsp_err` is valid, then the state moves to GAP. Write responses drive `rsp_rdata` = 0.
- **GAP.** Count `GAP_CYC` cycles with `mc_cmd_n` = 1, then return to IDLE. No request is accepted during GAP.
- **Reset.** Reset mid-transaction abandons it with no response; the controller is reset by the same system reset.
- **Reset values:**
  - `req_ready` 0, `rsp_vld` 0, `rsp_rdata` 0, `rsp_err` 0, `busy` 0.
  - `mc_cmd_n` 1, `mc_rdnwr` 1, `mc_addr` 0, `mc_wdata` 0, `mc_wdata_vld` 0.
  - State IDLE.

## Timing
- **Accept to `mc_cmd_n` low:** 1 cycle, because `mc_*` are registered.
- **Write latency:** accept edge, then N cycles in WAIT until CMD_WRITE is seen, then RESP on the next edge. `rsp_vld` is high 1 cycle after the completion cycle.
- **Read latency:** `rsp_vld` is high 2 cycles after CMD_READ is seen: one cycle in CAPT, one in RESP. The controller's `Data_out` is valid in the CAPT cycle.
- **Throughput:** the minimum spacing between accepts is the WAIT length + 1 (CAPT, reads only) + 1 (RESP) + `GAP_CYC` + 1 (IDLE).
- **Counter widths:** the timeout counter is 8 bits and saturates; the gap counter is 4 bits.
- **Stall:** a requester holding `req_vld` high while ungranted keeps its request until it is granted; there is no request dropping.

## Structure
- Shared package `mem_pkg`:
  - `cmd_t` encodings (NOP 000, ACT 001, READ 010, WRITE 011, PRE 100, REFRESH 101).
  - `arb_state_t`.
  - Address split constants: row `[15:12]`, column `[11:0]`.
  - `mem_ctrl` is to import `cmd_t` from this package as well.
- One sub-module, `rr_arb2`: combinational 2-way round-robin grant taking `req[1:0]` and `last_grant`, producing a one-hot `gnt[1:0]`.
- Top: FSM, request capture registers and counters.

## Test plan
- **Port-0 write:** `addr=16'h3A10`, `wdata=32'hDEADBEEF`; bench model raises CMD_WRITE 8 cycles later -> `mc_cmd_n` low for exactly 8 cycles, `rsp_vld=2'b01` one cycle after, `rsp_err=0`.
- **Port-1 read:** `addr=16'h3A10`; model returns CMD_READ and then `Data_out=32'hDEADBEEF` -> `rsp_vld=2'b10` two cycles after CMD_READ, `rsp_rdata=32'hDEADBEEF`.
- **Both ports valid continuously, four transactions:** grants alternate 0, 1, 0, 1; `mc_cmd_n` stays high for `GAP_CYC=2` cycles between transactions.
- **Model never completes:** `rsp_vld` rises at WAIT cycle 64 with `rsp_err=1` and `rsp_rdata=0`; the next request is accepted normally.
- **Read request while the model emits CMD_WRITE:** CMD_WRITE is ignored and the port waits for CMD_READ. CMD_READ arriving on the same cycle the timeout fires -> `rsp_err=0`.
- **`rst` asserted for 1 cycle mid-WAIT:** all outputs return to reset values on the next edge, no `rsp_vld` is produced, and port 0 wins the next conflict.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: command encodings, arbiter state codes and address split shared with mem_ctrl
package mem_pkg;
   typedef enum logic [2:0] {
      CMD_NOP     = 3'b000,
      CMD_ACT     = 3'b001,
      CMD_READ    = 3'b010,
      CMD_WRITE   = 3'b011,
      CMD_PRE     = 3'b100,
      CMD_REFRESH = 3'b101
   } cmd_t;
   typedef logic [2:0] arb_state_t;
   localparam arb_state_t ST_IDLE = 3'd0;
   localparam arb_state_t ST_WAIT = 3'd1;
   localparam arb_state_t ST_CAPT = 3'd2;
   localparam arb_state_t ST_RESP = 3'd3;
   localparam arb_state_t ST_GAP  = 3'd4;
   localparam int ROW_MSB = 15;
   localparam int ROW_LSB = 12;
   localparam int COL_MSB = 11;
   localparam int COL_LSB = 0;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant, one-hot output
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);
   always_comb gnt = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-port round-robin front end serialising requests onto mem_ctrl
module mem_req_arbiter
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int GAP_CYC     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_vld,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req_rdnwr,
   input  logic [1:0][15:0] req_addr,
   input  logic [1:0][31:0] req_wdata,
   output logic [1:0]       rsp_vld,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   output logic             busy,
   output logic             mc_cmd_n,
   output logic             mc_rdnwr,
   output logic [15:0]      mc_addr,
   output logic [31:0]      mc_wdata,
   output logic             mc_wdata_vld,
   input  logic [2:0]       mc_command,
   input  logic [31:0]      mc_rdata
);
   arb_state_t state;
   logic       last_grant;
   logic       port;
   logic [7:0] tcnt;
   logic [3:0] gcnt;
   logic [1:0] gnt;
   logic       accept;
   logic       done;
   logic       tmo;
   rr_arb2 u_arb (
      .req        (req_vld),
      .last_grant (last_grant),
      .gnt        (gnt)
   );
   always_comb begin
      req_ready = (state == ST_IDLE) ? gnt : 2'b00;
      accept    = |(req_vld & req_ready);
      // only the command matching the request direction completes it
      done      = (state == ST_WAIT) && (mc_command == (mc_rdnwr ? CMD_READ : CMD_WRITE));
      tmo       = (state == ST_WAIT) && (tcnt == 8'(TIMEOUT_CYC - 1));
      rsp_vld   = (state == ST_RESP) ? (port ? 2'b10 : 2'b01) : 2'b00;
      busy      = state != ST_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         last_grant   <= 1'b1;
         port         <= 1'b0;
         tcnt         <= '0;
         gcnt         <= '0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         mc_cmd_n     <= 1'b1;
         mc_rdnwr     <= 1'b1;
         mc_addr      <= '0;
         mc_wdata     <= '0;
         mc_wdata_vld <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               port         <= gnt[1];
               last_grant   <= gnt[1];
               mc_addr      <= req_addr[gnt[1]];
               mc_rdnwr     <= req_rdnwr[gnt[1]];
               mc_wdata     <= req_wdata[gnt[1]];
               mc_wdata_vld <= ~req_rdnwr[gnt[1]];
               mc_cmd_n     <= 1'b0;
               tcnt         <= '0;
               state        <= ST_WAIT;
            end
            ST_WAIT: if (done || tmo) begin
               mc_cmd_n     <= 1'b1;
               mc_wdata_vld <= 1'b0;
               rsp_err      <= ~done;
               rsp_rdata    <= '0;
               state        <= (done && mc_rdnwr) ? ST_CAPT : ST_RESP;
            end else begin
               tcnt <= (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
            end
            ST_CAPT: begin
               rsp_rdata <= mc_rdata;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               gcnt  <= '0;
               state <= ST_GAP;
            end
            ST_GAP: begin
               gcnt  <= gcnt + 4'd1;
               state <= (gcnt == 4'(GAP_CYC - 1)) ? ST_IDLE : ST_GAP;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized scoreboard bench with a behavioural mem_ctrl model
module tb_mem_req_arbiter;
   localparam int T = 64;
   localparam int G = 2;
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       req_vld = '0;
   logic [1:0]       req_ready;
   logic [1:0]       req_rdnwr = '0;
   logic [1:0][15:0] req_addr = '0;
   logic [1:0][31:0] req_wdata = '0;
   logic [1:0]       rsp_vld;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic             busy;
   logic             mc_cmd_n;
   logic             mc_rdnwr;
   logic [15:0]      mc_addr;
   logic [31:0]      mc_wdata;
   logic             mc_wdata_vld;
   logic [2:0]       mc_command = 3'b000;
   logic [31:0]      mc_rdata = '0;

   mem_req_arbiter #(.TIMEOUT_CYC(T), .GAP_CYC(G)) dut (
      .clk(clk), .rst(rst), .req_vld(req_vld), .req_ready(req_ready), .req_rdnwr(req_rdnwr),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy), .mc_cmd_n(mc_cmd_n), .mc_rdnwr(mc_rdnwr), .mc_addr(mc_addr),
      .mc_wdata(mc_wdata), .mc_wdata_vld(mc_wdata_vld), .mc_command(mc_command), .mc_rdata(mc_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  vld;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   // per-port plan: completion delay in WAIT cycles (0 = never) and cycle of a wrong-direction command
   int          pl_delay[2];
   int          pl_wrong[2];
   logic        pl_rd[2];
   logic [15:0] pl_addr[2];
   logic [31:0] pl_data[2];
   int          cur_delay = 0;
   int          cur_wrong = 0;
   logic        cur_rd = 1'b0;
   logic [15:0] cur_addr = '0;
   logic [31:0] cur_data = '0;
   logic        last = 1'b1;
   int wait_lo = 1, wait_hi = 0, busy_lo = 1, busy_hi = 0;
   logic chk_rst = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc);
      end
   endtask

   // behavioural controller: counts cycles with cmd_n low and answers per the plan
   int   k = 0;
   logic prev_read = 1'b0;
   always @(negedge clk) begin
      logic [2:0] c;
      k = (rst || mc_cmd_n) ? 0 : k + 1;
      mc_rdata = prev_read ? cur_data : $urandom;
      c = 3'b000;
      if (k != 0 && k == cur_delay) c = cur_rd ? 3'b010 : 3'b011;
      else if (k != 0 && k == cur_wrong) c = cur_rd ? 3'b011 : 3'b010;
      else if (k != 0 && $urandom_range(3) == 0) c = $urandom_range(1) ? 3'b001 : 3'b100;
      prev_read = (c == 3'b010);
      mc_command = c;
   end

   // monitor and scoreboard
   always @(negedge clk) begin
      logic       mb;
      logic [1:0] eg;
      logic [1:0] acc;
      exp_t       x;
      int         e, d, wl, p;
      logic       cpl;
      if (rst) begin
         sb.delete();
         last = 1'b1;
         wait_lo = 1; wait_hi = 0; busy_lo = 1; busy_hi = 0;
         chk_rst = 1'b1;
      end else begin
         if (chk_rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mc_cmd_n", mc_cmd_n, 1);
            chk("rst_mc_rdnwr", mc_rdnwr, 1);
            chk("rst_mc_addr", mc_addr, 0);
            chk("rst_mc_wdata", mc_wdata, 0);
            chk("rst_mc_wdata_vld", mc_wdata_vld, 0);
            chk_rst = 1'b0;
         end
         mb = (cyc >= busy_lo) && (cyc <= busy_hi);
         eg = (req_vld == 2'b11) ? (last ? 2'b01 : 2'b10) : req_vld;
         chk("req_ready", req_ready, mb ? 2'b00 : eg);
         chk("busy", busy, mb);
         chk("mc_cmd_n", mc_cmd_n, !((cyc >= wait_lo) && (cyc <= wait_hi)));
         if (!mc_cmd_n) begin
            chk("mc_addr", mc_addr, cur_addr);
            chk("mc_rdnwr", mc_rdnwr, cur_rd);
            chk("mc_wdata_vld", mc_wdata_vld, !cur_rd);
            if (!cur_rd) chk("mc_wdata", mc_wdata, cur_data);
         end
         if (rsp_vld != 2'b00) begin
            if (sb.size() == 0) chk("unexpected_rsp", rsp_vld, 0);
            else begin
               x = sb.pop_front();
               chk("rsp_vld", rsp_vld, x.vld);
               chk("rsp_err", rsp_err, x.err);
               chk("rsp_rdata", rsp_rdata, x.rdata);
               chk("rsp_cycle", cyc, x.cyc);
            end
         end
         acc = req_vld & req_ready;
         if (acc != 2'b00) begin
            p = acc[1] ? 1 : 0;
            e = cyc + 1;
            d = pl_delay[p];
            cpl = (d != 0) && (d <= T);
            wl = cpl ? d : T;
            x.vld = p ? 2'b10 : 2'b01;
            x.err = !cpl;
            x.rdata = (cpl && pl_rd[p]) ? pl_data[p] : 32'h0;
            x.cyc = e + wl + ((cpl && pl_rd[p]) ? 1 : 0);
            sb.push_back(x);
            wait_lo = e; wait_hi = e + wl - 1;
            busy_lo = e; busy_hi = x.cyc + G;
            cur_delay = d; cur_wrong = pl_wrong[p]; cur_rd = pl_rd[p];
            cur_addr = pl_addr[p]; cur_data = pl_data[p];
            last = acc[1];
         end
      end
   end

   task automatic issue(input int p, input logic rd, input logic [15:0] a, input logic [31:0] dt,
                        input int dly, input int wr);
      bit ok = 0;
      pl_delay[p] = dly; pl_wrong[p] = wr; pl_rd[p] = rd; pl_addr[p] = a; pl_data[p] = dt;
      @(posedge clk); #1;
      req_rdnwr[p] = rd; req_addr[p] = a; req_wdata[p] = dt; req_vld[p] = 1'b1;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         ok = req_vld[p] && req_ready[p];
      end
      if (!ok) begin errs++; $display("FAIL accept_timeout: port %0d never granted", p); end
      @(posedge clk); #1;
      req_vld[p] = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         ok = (sb.size() == 0) && (cyc > busy_hi);
      end
      if (!ok) begin errs++; $display("FAIL done_timeout: %0d responses outstanding", sb.size()); end
   endtask

   task automatic rnd_port(input int p);
      int r, dly;
      for (int n = 0; n < 12; n++) begin
         repeat ($urandom_range(5)) @(posedge clk);
         r = $urandom_range(9);
         dly = (r == 0) ? 0 : (r == 1) ? $urandom_range(60, 66) : $urandom_range(1, 20);
         issue(p, 1'($urandom_range(1)), 16'($urandom), $urandom, dly, $urandom_range(3));
      end
   endtask

   initial begin
      #(20000 * 10);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      issue(0, 1'b0, 16'h3A10, 32'hDEADBEEF, 8, 0);
      wait_done();
      issue(1, 1'b1, 16'h3A10, 32'hDEADBEEF, 5, 0);
      wait_done();
      fork
         begin issue(0, 1'b0, 16'h1111, 32'hA5A5A5A5, 4, 0); issue(0, 1'b1, 16'h2222, 32'h01234567, 3, 0); end
         begin issue(1, 1'b1, 16'h3333, 32'h89ABCDEF, 6, 0); issue(1, 1'b0, 16'h4444, 32'h5A5A5A5A, 2, 1); end
      join
      wait_done();
      issue(0, 1'b0, 16'h0F0F, 32'hCAFEF00D, 0, 2);
      wait_done();
      issue(1, 1'b0, 16'hF0F0, 32'h0BADBEEF, 3, 0);
      wait_done();
      issue(1, 1'b1, 16'h7777, 32'h13579BDF, T, 3);
      wait_done();
      issue(0, 1'b1, 16'h8888, 32'h2468ACE0, T + 1, 2);
      wait_done();
      issue(0, 1'b1, 16'h9999, 32'h11223344, 0, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      fork
         issue(0, 1'b0, 16'hAAAA, 32'h55667788, 2, 0);
         issue(1, 1'b1, 16'hBBBB, 32'h99AABBCC, 2, 0);
      join
      wait_done();
      fork
         rnd_port(0);
         rnd_port(1);
      join
      wait_done();
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
